bus_read_ctrl: RTL
==================

Name: bus_read_ctrl

Overview:
- Master-side reader for the shared tristate MCU data bus.
- Peripherals drive the bus through enable-gated tristate buffers; this block is the other end of that path.
- Per request it issues an address and a read strobe, waits for the peripheral's acknowledge and a settle interval, then captures the resolved bus value.
- Returns the captured data to the core over a valid/ready response channel and guarantees bus turnaround between transactions.

Parameters:
- DW, 8, data bus width.
- AW, 4, peripheral address width.
- SETTLE, 1, cycles to wait after bus_ack before sampling (range 0..7).
- TIMEOUT, 15, maximum cycles in STROBE without bus_ack before an error response (range 1..255).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high.
- req_valid  in  1  core read request.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_addr  in  AW  peripheral address, captured on accept.
- bus_addr  out  AW  address presented to the peripheral decoders.
- bus_rd  out  1  read strobe; the addressed peripheral enables its tristate driver while this is high.
- bus_drv_en  out  1  enable for the master's own bus driver; forced 0 whenever this block owns the bus.
- bus_data  in  DW  resolved bus value.
- bus_ack  in  1  peripheral data-driven acknowledge.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts the response.
- rsp_data  out  DW  captured data.
- rsp_err  out  1  timeout flag for the current response.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: req_ready=1, bus_addr=0, bus_rd=0, bus_drv_en=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, state=IDLE, counters=0.
- Reset applied mid-transaction: state returns to IDLE on the next edge, bus_rd drops the same edge, any pending response is discarded.
- All outputs are registered.
- State machine states: IDLE, ADDR, STROBE, SETTLE, CAPTURE, RESP, TURN.
- IDLE:
  - req_ready=1.
  - On accept, latch req_addr into bus_addr and go to ADDR.
  - req_ready falls the cycle after accept and stays 0 until the block is back in IDLE.
- ADDR:
  - One cycle with bus_rd=0 and bus_drv_en=0 (address setup and turnaround), then go to STROBE.
- STROBE:
  - bus_rd=1; the timeout counter increments each cycle.
  - If bus_ack is high, go to SETTLE, or directly to CAPTURE when SETTLE=0.
  - If the counter reaches TIMEOUT with no ack, set rsp_err=1, set rsp_data to all ones, go to RESP.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
- SETTLE:
  - bus_rd stays 1; count SETTLE cycles, then go to CAPTURE.
  - A bus_ack drop during SETTLE is ignored.
- CAPTURE:
  - rsp_data<=bus_data, rsp_err<=0, bus_rd<=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err hold stable until rsp_ready is high.
  - On handshake, rsp_valid<=0 and go to TURN.
  - rsp_ready is ignored while rsp_valid=0.
- TURN:
  - One idle cycle with bus_rd=0, so two peripherals never overlap on the bus; then go to IDLE.
- Latency, ack present in the first STROBE cycle, SETTLE=1, rsp_ready held high:
  - Accept at edge 0: ADDR at 1, STROBE at 2, SETTLE at 3, CAPTURE at 4, rsp_valid at 5, TURN at 6, IDLE at 7.
  - Minimum request-to-request spacing is 7 cycles.
- Invariants:
  - bus_drv_en=0 in every state; the block never drives the bus.
  - bus_addr changes only on accept.
  - Exactly one response per accepted request.
  - Counters reset on entry to STROBE and SETTLE.
  - TIMEOUT counter width is 8 bits; SETTLE counter width is 3 bits.

Test Plan:
- Basic read: req_addr=4'h3, peripheral acks on the first STROBE cycle and drives 8'hA5 -> rsp_valid at cycle 5 after accept, rsp_data=8'hA5, rsp_err=0, bus_rd high for exactly 2 cycles.
- Timeout: no bus_ack, TIMEOUT=15 -> bus_rd high for 15 cycles, then rsp_valid with rsp_err=1 and rsp_data=8'hFF; the next request is accepted normally.
- Backpressure: rsp_ready low for 10 cycles, bus_data changes to 8'h00 after capture -> rsp_data stays 8'h3C, rsp_valid stays high, req_ready stays 0, a single response is delivered.
- Ack and timeout coincide: bus_ack first asserted on the 15th STROBE cycle -> success, rsp_err=0, rsp_data equals the bus value.
- Reset mid-STROBE: rst for 1 cycle -> next edge shows IDLE, bus_rd=0, rsp_valid=0, req_ready=1; no stale response appears afterwards.
- Back-to-back requests to addresses 1 then 2 -> a TURN cycle with bus_rd=0 separates the two strobes; bus_addr changes only on the second accept; both responses arrive in order.

Source files
------------

// File: rtl/bus_read_ctrl.sv
// Master-side reader for the shared tristate data bus: address, strobe, wait for ack and settle,
// capture the resolved value and return it over a valid/ready response channel.
module bus_read_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 4,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic [AW-1:0] bus_addr,
    output logic          bus_rd,
    output logic          bus_drv_en,
    input  logic [DW-1:0] bus_data,
    input  logic          bus_ack,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT);
    localparam logic [2:0] SettleLast  = 3'(SETTLE);

    typedef enum logic [2:0] {
        StIdle, StAddr, StStrobe, StSettle, StCapture, StResp, StTurn
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic [2:0]    st_cnt_q, st_cnt_d;
    logic          req_ready_q, req_ready_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic          bus_rd_q, bus_rd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          busy_q, busy_d;
    logic          bus_drv_en_q;

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        st_cnt_d   = st_cnt_q;
        bus_addr_d = bus_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    bus_addr_d = req_addr;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                to_cnt_d = '0;
                state_d  = StStrobe;
            end
            StStrobe: begin
                to_cnt_d = to_cnt_q + 8'd1;
                // Ack takes priority over a timeout reached in the same cycle.
                if (bus_ack) begin
                    st_cnt_d = '0;
                    state_d  = (SETTLE == 0) ? StCapture : StSettle;
                end else if (to_cnt_d == TimeoutLast) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '1;
                    state_d    = StResp;
                end
            end
            StSettle: begin
                st_cnt_d = st_cnt_q + 3'd1;
                if (st_cnt_d == SettleLast) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                rsp_data_d = bus_data;
                rsp_err_d  = 1'b0;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StTurn;
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        req_ready_d = (state_d == StIdle);
        bus_rd_d    = (state_d == StStrobe) || (state_d == StSettle);
        rsp_valid_d = (state_d == StResp);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            to_cnt_q     <= '0;
            st_cnt_q     <= '0;
            req_ready_q  <= 1'b1;
            bus_addr_q   <= '0;
            bus_rd_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            bus_drv_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            st_cnt_q     <= st_cnt_d;
            req_ready_q  <= req_ready_d;
            bus_addr_q   <= bus_addr_d;
            bus_rd_q     <= bus_rd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            bus_drv_en_q <= 1'b0;
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_addr   = bus_addr_q;
    assign bus_rd     = bus_rd_q;
    assign bus_drv_en = bus_drv_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule
